router_pkt_receiver: RTL

ROUTER_PKT_RECEIVER -- requirements
Module: router_pkt_receiver

---
 rtl/router_pkt_receiver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/router_pkt_receiver.sv
// Router output-port packet receiver: drains one FIFO, strips the header,
// streams the payload downstream and checks parity, address and truncation.
module router_pkt_receiver #(
  parameter logic [1:0]  EXP_ADDR   = 2'd0,
  parameter int unsigned READ_DELAY = 0,
  parameter int unsigned TIMEOUT    = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_out,
  input  logic [7:0] data_out,
  input  logic       sink_ready,
  output logic       read_enb,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [1:0] pkt_addr,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       trunc_err,
  output logic [7:0] pkt_count
);

  typedef enum logic [2:0] {
    IDLE, DELAY, HDR_RD, HDR_CAP, BODY, DONE
  } state_t;

  localparam logic [4:0] DLY_LAST =
    (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;
  localparam logic [7:0] IDLE_LAST =
    (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  state_t     state_q;
  logic       pend_q;
  logic [6:0] issue_q;
  logic [6:0] rx_q;
  logic [7:0] par_q;
  logic [4:0] dly_q;
  logic [7:0] idle_q;

  logic       acc;
  logic [6:0] rx_d;
  logic       fin_par;
  logic       fin_to;

  // Read strobe: only header fetch and flow-controlled body reads.
  always_comb begin
    read_enb = 1'b0;
    if (!reset) begin
      case (state_q)
        HDR_RD: read_enb = valid_out;
        BODY:   read_enb = valid_out && sink_ready
                           && (issue_q != 7'd0);
        default: read_enb = 1'b0;
      endcase
    end
  end

  // Packet-end detection: parity byte captured, or idle timeout in body.
  always_comb begin
    acc     = read_enb && valid_out;
    rx_d    = rx_q + 7'd1;
    fin_par = (state_q == BODY) && pend_q
              && (rx_d > {1'b0, pkt_len});
    fin_to  = (state_q == BODY) && !pend_q && !acc
              && (idle_q == IDLE_LAST);
  end

  // Receive FSM with registered status and payload outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      issue_q    <= '0;
      rx_q       <= '0;
      par_q      <= '0;
      dly_q      <= '0;
      idle_q     <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pkt_addr   <= '0;
      pkt_len    <= '0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      trunc_err  <= 1'b0;
      pkt_count  <= '0;
    end else begin
      pend_q     <= acc;
      byte_valid <= 1'b0;
      pkt_done   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_out) begin
            dly_q   <= '0;
            state_q <= (READ_DELAY > 0) ? DELAY : HDR_RD;
          end
        end
        DELAY: begin
          if (dly_q == DLY_LAST) state_q <= HDR_RD;
          else dly_q <= dly_q + 5'd1;
        end
        HDR_RD: begin
          if (acc) state_q <= HDR_CAP;
        end
        HDR_CAP: begin
          pkt_addr <= data_out[1:0];
          pkt_len  <= data_out[7:2];
          par_q    <= data_out;
          issue_q  <= {1'b0, data_out[7:2]} + 7'd1;
          rx_q     <= '0;
          idle_q   <= '0;
          state_q  <= BODY;
        end
        BODY: begin
          if (acc) issue_q <= issue_q - 7'd1;
          if (pend_q) begin
            idle_q <= '0;
            rx_q   <= rx_d;
            if (!fin_par) begin
              byte_out   <= data_out;
              byte_valid <= 1'b1;
              par_q      <= par_q ^ data_out;
            end
          end else if (acc) begin
            idle_q <= '0;
          end else if (!fin_to) begin
            idle_q <= idle_q + 8'd1;
          end
          if (fin_par || fin_to) begin
            state_q    <= DONE;
            pkt_done   <= 1'b1;
            parity_err <= fin_par && (par_q != data_out);
            trunc_err  <= fin_to;
            addr_err   <= (pkt_addr != EXP_ADDR);
            if (pkt_count != 8'hFF)
              pkt_count <= pkt_count + 8'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
